// File: rtl/cam_pkg.sv
// Shared camera-path types: capture FSM states, default geometry,
// and the RGB565 field layout used by the frame buffer and display.
package cam_pkg;

  typedef enum logic [1:0] {
    WAIT_VBLANK = 2'd0,
    WAIT_FV     = 2'd1,
    FRAME       = 2'd2
  } cam_state_t;

  localparam int CAM_H_PIXELS = 640;
  localparam int CAM_V_LINES  = 480;

  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic logic [15:0] rgb565_pair(
    input logic       hi_first,
    input logic [7:0] first,
    input logic [7:0] second
  );
    return hi_first ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Registers one camera strobe and flags its rising and falling edges
// against a second, delayed copy.
module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= din;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/cam_pixel_assembler.sv
// Pairs LV/FV-qualified sensor bytes into RGB565 pixels, tracks position,
// clips oversize frames and flags malformed lines.
module cam_pixel_assembler
  import cam_pkg::*;
#(
  parameter int H_PIXELS = CAM_H_PIXELS,
  parameter int V_LINES  = CAM_V_LINES,
  parameter int HI_FIRST = 1,
  parameter int HW       = 10,
  parameter int VW       = 9
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [7:0]    D_I,
  input  logic          LV_I,
  input  logic          FV_I,
  output logic [15:0]   D_O,
  output logic          DV_O,
  output logic          SOF_O,
  output logic          EOL_O,
  output logic [HW-1:0] HCNT_O,
  output logic [VW-1:0] VCNT_O,
  output logic          LINE_ERR_O,
  output logic          FRAME_DONE_O
);

  // Counters carry one spare bit so they can hold the full geometry.
  localparam logic [HW:0] H_END = H_PIXELS[HW:0];
  localparam logic [VW:0] V_END = V_LINES[VW:0];

  cam_state_t  state;
  logic [7:0]  d_r;
  logic [7:0]  hold;
  logic        lv_r, lv_rise, lv_fall;
  logic        fv_r, fv_rise, fv_fall;
  logic        primed;
  logic        phase;
  logic        in_line;
  logic        ovf;
  logic [HW:0] col;
  logic [VW:0] row;

  logic        take;
  logic        ph_eff;
  logic        ovf_eff;
  logic [HW:0] col_eff;
  logic        col_ok;
  logic        row_ok;
  logic        line_end;
  logic [15:0] pix;

  cam_sync_edge u_lv (
    .clk  (CLK_I),
    .rst  (RST_I),
    .din  (LV_I),
    .q    (lv_r),
    .rise (lv_rise),
    .fall (lv_fall)
  );

  cam_sync_edge u_fv (
    .clk  (CLK_I),
    .rst  (RST_I),
    .din  (FV_I),
    .q    (fv_r),
    .rise (fv_rise),
    .fall (fv_fall)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) d_r <= '0;
    else       d_r <= D_I;
  end

  always_comb begin
    take     = 1'b0;
    ph_eff   = phase;
    ovf_eff  = ovf;
    col_eff  = col;
    line_end = 1'b0;
    if (state == FRAME) begin
      take     = fv_r & lv_r & (in_line | lv_rise);
      line_end = in_line & (lv_fall | fv_fall);
    end
    if (lv_rise) begin
      ph_eff  = 1'b0;
      ovf_eff = 1'b0;
      col_eff = '0;
    end
    col_ok = col_eff < H_END;
    row_ok = row < V_END;
    pix    = rgb565_pair(HI_FIRST != 0, hold, d_r);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state        <= WAIT_VBLANK;
      primed       <= 1'b0;
      hold         <= '0;
      phase        <= 1'b0;
      in_line      <= 1'b0;
      ovf          <= 1'b0;
      col          <= '0;
      row          <= '0;
      D_O          <= '0;
      DV_O         <= 1'b0;
      SOF_O        <= 1'b0;
      EOL_O        <= 1'b0;
      HCNT_O       <= '0;
      VCNT_O       <= '0;
      LINE_ERR_O   <= 1'b0;
      FRAME_DONE_O <= 1'b0;
    end else begin
      primed       <= 1'b1;
      DV_O         <= 1'b0;
      SOF_O        <= 1'b0;
      EOL_O        <= 1'b0;
      LINE_ERR_O   <= 1'b0;
      FRAME_DONE_O <= 1'b0;

      // fv_r is only trusted once a post-reset sample has landed.
      unique case (state)
        WAIT_VBLANK: if (primed && !fv_r) state <= WAIT_FV;
        WAIT_FV: begin
          if (fv_rise) begin
            row   <= '0;
            state <= FRAME;
          end
        end
        FRAME: begin
          if (fv_fall) begin
            FRAME_DONE_O <= 1'b1;
            state        <= WAIT_FV;
          end
        end
        default: state <= WAIT_VBLANK;
      endcase

      if (take) begin
        in_line <= 1'b1;
        phase   <= ~ph_eff;
        col     <= col_eff;
        ovf     <= ovf_eff;
        if (!ph_eff) begin
          hold <= d_r;
        end else if (col_ok && row_ok) begin
          D_O    <= pix;
          DV_O   <= 1'b1;
          SOF_O  <= (col_eff == '0) && (row == '0);
          EOL_O  <= col_eff == H_END - 1'b1;
          HCNT_O <= col_eff[HW-1:0];
          VCNT_O <= row[VW-1:0];
          col    <= col_eff + 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end

      if (line_end) begin
        in_line <= 1'b0;
        phase   <= 1'b0;
        ovf     <= 1'b0;
        if (row_ok) begin
          LINE_ERR_O <= phase | (col < H_END) | ovf;
          row        <= row + 1'b1;
        end
      end

      if (state != FRAME) in_line <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cam_pixel_assembler.sv
// Bench for cam_pixel_assembler: high-first and low-first instances share
// one sensor stimulus and are scored against a line-level reference model.
module tb_cam_pixel_assembler;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int HW = 4;
  localparam int VW = 3;

  typedef struct packed {
    logic [15:0]   d;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          sof;
    logic          eol;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    d_in = '0;
  logic          lv = 1'b0;
  logic          fv = 1'b0;
  logic [15:0]   d_a, d_b;
  logic          dv_a, dv_b, sof_a, sof_b, eol_a, eol_b;
  logic          err_a, err_b, done_a, done_b;
  logic [HW-1:0] hc_a, hc_b;
  logic [VW-1:0] vc_a, vc_b;

  always #5 clk = ~clk;

  cam_pixel_assembler #(
    .H_PIXELS(H), .V_LINES(V), .HI_FIRST(1), .HW(HW), .VW(VW)
  ) dut_a (
    .CLK_I(clk), .RST_I(rst), .D_I(d_in), .LV_I(lv), .FV_I(fv),
    .D_O(d_a), .DV_O(dv_a), .SOF_O(sof_a), .EOL_O(eol_a),
    .HCNT_O(hc_a), .VCNT_O(vc_a), .LINE_ERR_O(err_a),
    .FRAME_DONE_O(done_a)
  );

  cam_pixel_assembler #(
    .H_PIXELS(H), .V_LINES(V), .HI_FIRST(0), .HW(HW), .VW(VW)
  ) dut_b (
    .CLK_I(clk), .RST_I(rst), .D_I(d_in), .LV_I(lv), .FV_I(fv),
    .D_O(d_b), .DV_O(dv_b), .SOF_O(sof_b), .EOL_O(eol_b),
    .HCNT_O(hc_b), .VCNT_O(vc_b), .LINE_ERR_O(err_b),
    .FRAME_DONE_O(done_b)
  );

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  pix_t got_a[$], got_b[$], exp_a[$], exp_b[$];
  int   dv_cyc_b[$];
  int   n_err_a, n_err_b, n_done_a, n_done_b;
  int   exp_err, exp_done;
  int   err_cyc, done_cyc;
  int   sec_cyc;
  int   lv_low_cyc[8];
  int   line_len[8];
  logic [7:0] dat[8][16];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dv_a) got_a.push_back(pix_t'{d_a, hc_a, vc_a, sof_a, eol_a});
    if (dv_b) begin
      got_b.push_back(pix_t'{d_b, hc_b, vc_b, sof_b, eol_b});
      dv_cyc_b.push_back(cyc);
    end
    if (err_a) begin
      n_err_a++;
      err_cyc = cyc;
    end
    if (err_b) n_err_b++;
    if (done_a) begin
      n_done_a++;
      done_cyc = cyc;
    end
    if (done_b) n_done_b++;
  end

  task automatic step(input logic f, input logic l, input logic [7:0] d);
    @(posedge clk);
    #1;
    fv   = f;
    lv   = l;
    d_in = d;
  endtask

  task automatic clear();
    got_a.delete();
    got_b.delete();
    exp_a.delete();
    exp_b.delete();
    dv_cyc_b.delete();
    n_err_a = 0; n_err_b = 0; n_done_a = 0; n_done_b = 0;
    exp_err = 0; exp_done = 0;
    err_cyc = -1; done_cyc = -2;
  endtask

  // mode 1: bytes 1..n, otherwise random
  task automatic set_line(input int l, input int n, input int mode);
    line_len[l] = n;
    for (int b = 0; b < n; b++)
      dat[l][b] = (mode == 1) ? 8'(b + 1) : 8'($urandom_range(0, 255));
  endtask

  // Reference: each line of n bytes yields min(n/2, H) pixels while
  // the line index is inside the frame; a line is bad if n != 2*H.
  task automatic model_frame(input int nl);
    pix_t pa, pb;
    int   np;
    for (int l = 0; l < nl; l++) begin
      if (l < V) begin
        np = line_len[l] / 2;
        for (int k = 0; k < np && k < H; k++) begin
          pa.d   = {dat[l][2*k], dat[l][2*k+1]};
          pa.h   = HW'(k);
          pa.v   = VW'(l);
          pa.sof = (k == 0) && (l == 0);
          pa.eol = (k == H - 1);
          pb     = pa;
          pb.d   = {dat[l][2*k+1], dat[l][2*k]};
          exp_a.push_back(pa);
          exp_b.push_back(pb);
        end
        if (line_len[l] != 2 * H) exp_err++;
      end
    end
    exp_done++;
  endtask

  task automatic drive_frame(input int nl);
    step(1, 0, 0);
    step(1, 0, 0);
    for (int l = 0; l < nl; l++) begin
      for (int b = 0; b < line_len[l]; b++) begin
        step(1, 1, dat[l][b]);
        if (l == 0 && b == 1) sec_cyc = cyc;
      end
      step(1, 0, 0);
      lv_low_cyc[l] = cyc;
      step(1, 0, 0);
      step(1, 0, 0);
    end
    repeat (6) step(0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step(0, 0, 8'h5A);
    n_chk++;
    if ({dv_a, sof_a, eol_a, err_a, done_a, dv_b} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 000000",
               {dv_a, sof_a, eol_a, err_a, done_a, dv_b});
    end
    n_chk++;
    if (d_a !== 16'h0 || d_b !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h want 0", d_a, d_b);
    end
    n_chk++;
    if (hc_a !== '0 || vc_a !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", hc_a, vc_a);
    end
    rst = 1'b0;
    clear();
    repeat (5) step(0, 0, 0);
    n_chk++;
    if (got_a.size() != 0 || n_err_a != 0 || n_done_a != 0) begin
      n_fail++;
      $display("FAIL reset_idle: got %0d pix %0d err %0d done want 0",
               got_a.size(), n_err_a, n_done_a);
    end
  endtask

  task automatic test_basic_frame();
    clear();
    set_line(0, 8, 1);
    set_line(1, 8, 1);
    model_frame(2);
    drive_frame(2);
    n_chk++;
    if (got_a.size() == 0 || got_a[0] !== pix_t'{16'h0102, 4'd0, 3'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_first: got %h want %h", got_a[0],
               pix_t'{16'h0102, 4'd0, 3'd0, 1'b1, 1'b0});
    end
    n_chk++;
    if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
      n_fail++;
      $display("FAIL basic_npix: got %0d/%0d want %0d", got_a.size(),
               got_b.size(), exp_a.size());
    end
    foreach (exp_a[i]) begin
      n_chk++;
      if (i >= got_a.size() || i >= got_b.size() ||
          got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL basic_pix[%0d]: got %h/%h want %h/%h", i,
                 got_a[i], got_b[i], exp_a[i], exp_b[i]);
      end
    end
    n_chk++;
    if (n_err_a != exp_err || n_err_b != exp_err ||
        n_done_a != exp_done || n_done_b != exp_done) begin
      n_fail++;
      $display("FAIL basic_flags: err %0d/%0d done %0d/%0d want %0d %0d",
               n_err_a, n_err_b, n_done_a, n_done_b, exp_err, exp_done);
    end
  endtask

  task automatic test_lo_first_latency();
    clear();
    set_line(0, 8, 0);
    dat[0][0] = 8'hAB;
    dat[0][1] = 8'hCD;
    model_frame(1);
    drive_frame(1);
    n_chk++;
    if (got_b.size() == 0 || got_b[0].d !== 16'hCDAB) begin
      n_fail++;
      $display("FAIL lo_first_data: got %h want cdab", got_b[0].d);
    end
    n_chk++;
    if (got_a.size() == 0 || got_a[0].d !== 16'hABCD) begin
      n_fail++;
      $display("FAIL hi_first_data: got %h want abcd", got_a[0].d);
    end
    n_chk++;
    if (dv_cyc_b.size() == 0 || dv_cyc_b[0] != sec_cyc + 2) begin
      n_fail++;
      $display("FAIL latency: got cycle %0d want %0d", dv_cyc_b[0], sec_cyc + 2);
    end
  endtask

  task automatic test_odd_line();
    clear();
    set_line(0, 7, 0);
    set_line(1, 8, 0);
    model_frame(2);
    drive_frame(2);
    n_chk++;
    if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
      n_fail++;
      $display("FAIL odd_npix: got %0d/%0d want %0d", got_a.size(),
               got_b.size(), exp_a.size());
    end
    foreach (exp_a[i]) begin
      n_chk++;
      if (i >= got_a.size() || i >= got_b.size() ||
          got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL odd_pix[%0d]: got %h/%h want %h/%h", i,
                 got_a[i], got_b[i], exp_a[i], exp_b[i]);
      end
    end
    n_chk++;
    if (n_err_a != exp_err || n_err_b != exp_err || n_done_a != exp_done) begin
      n_fail++;
      $display("FAIL odd_flags: err %0d/%0d done %0d want %0d %0d",
               n_err_a, n_err_b, n_done_a, exp_err, exp_done);
    end
    n_chk++;
    if (err_cyc != lv_low_cyc[0] + 2) begin
      n_fail++;
      $display("FAIL odd_err_time: got cycle %0d want %0d", err_cyc,
               lv_low_cyc[0] + 2);
    end
  endtask

  task automatic test_overflow_extra_line();
    clear();
    set_line(0, 12, 0);
    set_line(1, 8, 0);
    set_line(2, 8, 0);
    model_frame(3);
    drive_frame(3);
    n_chk++;
    if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
      n_fail++;
      $display("FAIL ovf_npix: got %0d/%0d want %0d", got_a.size(),
               got_b.size(), exp_a.size());
    end
    foreach (exp_a[i]) begin
      n_chk++;
      if (i >= got_a.size() || i >= got_b.size() ||
          got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL ovf_pix[%0d]: got %h/%h want %h/%h", i,
                 got_a[i], got_b[i], exp_a[i], exp_b[i]);
      end
    end
    n_chk++;
    if (n_err_a != exp_err || n_err_b != exp_err || n_done_a != exp_done) begin
      n_fail++;
      $display("FAIL ovf_flags: err %0d/%0d done %0d want %0d %0d",
               n_err_a, n_err_b, n_done_a, exp_err, exp_done);
    end
  endtask

  task automatic test_fv_drop();
    int fv_low;
    clear();
    set_line(0, 4, 0);
    model_frame(1);
    step(1, 0, 0);
    step(1, 0, 0);
    for (int b = 0; b < 4; b++) step(1, 1, dat[0][b]);
    step(0, 1, 0);
    fv_low = cyc;
    step(0, 1, 0);
    repeat (6) step(0, 0, 0);
    n_chk++;
    if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
      n_fail++;
      $display("FAIL fvdrop_npix: got %0d/%0d want %0d", got_a.size(),
               got_b.size(), exp_a.size());
    end
    foreach (exp_a[i]) begin
      n_chk++;
      if (i >= got_a.size() || got_a[i] !== exp_a[i]) begin
        n_fail++;
        $display("FAIL fvdrop_pix[%0d]: got %h want %h", i, got_a[i], exp_a[i]);
      end
    end
    n_chk++;
    if (n_err_a != 1 || n_done_a != 1 || err_cyc != done_cyc ||
        done_cyc != fv_low + 2) begin
      n_fail++;
      $display("FAIL fvdrop_pulse: err %0d@%0d done %0d@%0d want 1@%0d 1@%0d",
               n_err_a, err_cyc, n_done_a, done_cyc, fv_low + 2, fv_low + 2);
    end
    clear();
    set_line(0, 8, 0);
    set_line(1, 8, 0);
    model_frame(2);
    drive_frame(2);
    n_chk++;
    if (got_a.size() != exp_a.size() || n_done_a != 1 || n_err_a != 0) begin
      n_fail++;
      $display("FAIL fvdrop_next: got %0d pix %0d done %0d err want %0d 1 0",
               got_a.size(), n_done_a, n_err_a, exp_a.size());
    end
  endtask

  task automatic test_random_frames();
    int nl;
    clear();
    for (int f = 0; f < 4; f++) begin
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++)
        set_line(l, ($urandom_range(0, 1) == 1) ? 8 : $urandom_range(1, 11), 0);
      model_frame(nl);
      drive_frame(nl);
    end
    n_chk++;
    if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
      n_fail++;
      $display("FAIL rand_npix: got %0d/%0d want %0d", got_a.size(),
               got_b.size(), exp_a.size());
    end
    foreach (exp_a[i]) begin
      n_chk++;
      if (i >= got_a.size() || i >= got_b.size() ||
          got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL rand_pix[%0d]: got %h/%h want %h/%h", i,
                 got_a[i], got_b[i], exp_a[i], exp_b[i]);
      end
    end
    n_chk++;
    if (n_err_a != exp_err || n_err_b != exp_err ||
        n_done_a != exp_done || n_done_b != exp_done) begin
      n_fail++;
      $display("FAIL rand_flags: err %0d/%0d done %0d/%0d want %0d %0d",
               n_err_a, n_err_b, n_done_a, n_done_b, exp_err, exp_done);
    end
  endtask

  task automatic test_reset_mid_frame();
    step(1, 0, 0);
    step(1, 0, 0);
    for (int b = 0; b < 5; b++) step(1, 1, 8'($urandom_range(0, 255)));
    rst = 1'b1;
    step(1, 1, 8'h11);
    step(1, 1, 8'h22);
    rst = 1'b0;
    clear();
    step(1, 0, 0);
    for (int b = 0; b < 8; b++) step(1, 1, 8'($urandom_range(0, 255)));
    repeat (3) step(1, 0, 0);
    n_chk++;
    if (got_a.size() != 0 || got_b.size() != 0 || n_err_a != 0) begin
      n_fail++;
      $display("FAIL midrst_quiet: got %0d/%0d pix %0d err want 0",
               got_a.size(), got_b.size(), n_err_a);
    end
    repeat (6) step(0, 0, 0);
    n_chk++;
    if (n_done_a != 0) begin
      n_fail++;
      $display("FAIL midrst_done: got %0d want 0", n_done_a);
    end
    set_line(0, 8, 0);
    set_line(1, 8, 0);
    model_frame(2);
    drive_frame(2);
    n_chk++;
    if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
      n_fail++;
      $display("FAIL midrst_npix: got %0d/%0d want %0d", got_a.size(),
               got_b.size(), exp_a.size());
    end
    foreach (exp_a[i]) begin
      n_chk++;
      if (i >= got_a.size() || i >= got_b.size() ||
          got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL midrst_pix[%0d]: got %h/%h want %h/%h", i,
                 got_a[i], got_b[i], exp_a[i], exp_b[i]);
      end
    end
    n_chk++;
    if (n_err_a != exp_err || n_done_a != exp_done) begin
      n_fail++;
      $display("FAIL midrst_flags: err %0d done %0d want %0d %0d",
               n_err_a, n_done_a, exp_err, exp_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_lo_first_latency();
    test_odd_line();
    test_overflow_extra_line();
    test_fv_drop();
    test_random_frames();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
